// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic FIR engine.
// Holds the FSM state encoding and the width-derivation helpers.
// Pure declarations; no timing or flow control lives here.
package da_pkg;

  // Engine sequencing states; the encoding is fixed so it stays stable across builds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } da_state_e;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int da_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: coefficient, adder-tree growth and full sample weight.
  // With this width the shift-accumulate can never overflow.
  function automatic int da_acc_w(input int coef_w, input int nbank, input int data_w);
    return coef_w + da_clog2(nbank) + data_w;
  endfunction

  // Slice-index width: enough bits to count DATA_W slices, never zero.
  function automatic int da_idx_w(input int data_w);
    return (data_w > 1) ? da_clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/da_adder_tree.sv
// Pipelined binary adder tree summing NBANK signed LUT words.
// Latency: log2(NBANK) cycles, one registered level per tree level.
// No backpressure: a new set of words may enter every cycle.
module da_adder_tree
  import da_pkg::*;
#(
  parameter int NBANK  = 8,
  parameter int COEF_W = 20,
  parameter int IDX_W  = 4,
  localparam int LB    = da_clog2(NBANK),
  localparam int SUM_W = COEF_W + LB
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    vld_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [NBANK*COEF_W-1:0] dat_i,
  output logic                    vld_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic signed [SUM_W-1:0] sum_o
);

  // Level n holds NBANK>>n partial sums, each COEF_W+n bits wide.
  // Level 0 is the unregistered input; every later level is a register stage.
  for (genvar n = 0; n <= LB; n++) begin : g_lvl
    localparam int W   = COEF_W + n;
    localparam int CNT = NBANK >> n;

    logic signed [W-1:0] lvl_sum [CNT];
    logic                lvl_vld;
    logic [IDX_W-1:0]    lvl_idx;

    if (n == 0) begin : g_leaf
      for (genvar i = 0; i < CNT; i++) begin : g_word
        assign lvl_sum[i] = dat_i[i*COEF_W +: COEF_W];
      end
      assign lvl_vld = vld_i;
      assign lvl_idx = idx_i;
    end else begin : g_sum
      // Valid tag for this level; cleared on reset so no stale sum reaches the accumulator.
      always_ff @(posedge clk_i) begin
        if (reset_i) lvl_vld <= 1'b0;
        else         lvl_vld <= g_lvl[n-1].lvl_vld;
      end

      // Pairwise sign-extended adds plus the slice index travelling alongside.
      always_ff @(posedge clk_i) begin
        lvl_idx <= g_lvl[n-1].lvl_idx;
        for (int i = 0; i < CNT; i++) begin
          lvl_sum[i] <= {g_lvl[n-1].lvl_sum[2*i][W-2],   g_lvl[n-1].lvl_sum[2*i]}
                      + {g_lvl[n-1].lvl_sum[2*i+1][W-2], g_lvl[n-1].lvl_sum[2*i+1]};
        end
      end
    end
  end

  assign vld_o = g_lvl[LB].lvl_vld;
  assign idx_o = g_lvl[LB].lvl_idx;
  assign sum_o = g_lvl[LB].lvl_sum[0];

endmodule

// File: rtl/da_fir_engine.sv
// Distributed-arithmetic MAC: LUT read, adder tree, shift-accumulate over DATA_W bit-slices.
// Latency: last slice accepted at cycle T gives done at T+log2(NBANK)+3; one slice per cycle.
// Backpressure: slice_ready high only in RUN; bubbles allowed. Optional clamp via DA_SATURATE_EN.
module da_fir_engine
  import da_pkg::*;
#(
  parameter int NBANK  = 8,
  parameter int K      = 8,
  parameter int COEF_W = 20,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 24,
  localparam int LB    = da_clog2(NBANK),
  localparam int ACC_W = da_acc_w(COEF_W, NBANK, DATA_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cload,
  input  logic [LB+K-1:0]         caddr,
  input  logic signed [COEF_W-1:0] cin,
  input  logic                    start,
  input  logic [NBANK*K-1:0]      slice_in,
  input  logic                    slice_valid,
  output logic                    slice_ready,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] y_out
`ifdef DA_SATURATE_EN
  ,
  output logic                    sat
`endif
);

  localparam int IDX_W = da_idx_w(DATA_W);
  localparam int SUM_W = COEF_W + LB;
  localparam int DEPTH = NBANK << K;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  // Reject parameter sets the datapath was not built for.
  if (NBANK < 2 || NBANK > 16 || (1 << LB) != NBANK || OUT_W < 2 || OUT_W > ACC_W) begin : g_bad_param
    $error("da_fir_engine: unsupported parameter set");
  end

  da_state_e state_q, state_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic             slice_acc;

  logic signed [COEF_W-1:0] lut_mem [DEPTH];
  logic [NBANK*COEF_W-1:0]  lut_rd_q;
  logic                     rd_vld_q;
  logic [IDX_W-1:0]         rd_idx_q;

  logic                    tree_vld;
  logic [IDX_W-1:0]        tree_idx;
  logic signed [SUM_W-1:0] tree_sum;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_shift;
  logic                    acc_vld_q;
  logic [IDX_W-1:0]        acc_idx_q;

  logic signed [ACC_W-1:0] y_q, y_d;
  logic                    load_y;

  // Sequencing: IDLE waits for start, RUN takes DATA_W slices, DRAIN empties the pipe.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    slice_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          j_d     = '0;
        end
      end
      ST_RUN: begin
        if (slice_valid) begin
          slice_acc = 1'b1;
          j_d       = j_q + IDX_W'(1);
          if (j_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (acc_vld_q && acc_idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and slice counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
    end
  end

  assign slice_ready = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);

  // Coefficient writes only land while idle, so a running computation never sees a torn table.
  always_ff @(posedge clk) begin
    if (cload && state_q == ST_IDLE) lut_mem[caddr] <= cin;
  end

  // Registered LUT read: each bank is addressed by its K-bit field of the slice.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      lut_rd_q[b*COEF_W +: COEF_W] <= lut_mem[{LB'(b), slice_in[b*K +: K]}];
    end
  end

  // Read-stage valid tag and slice index.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= slice_acc;
      rd_idx_q <= j_q;
    end
  end

  da_adder_tree #(
    .NBANK (NBANK),
    .COEF_W(COEF_W),
    .IDX_W (IDX_W)
  ) u_tree (
    .clk_i  (clk),
    .reset_i(reset),
    .vld_i  (rd_vld_q),
    .idx_i  (rd_idx_q),
    .dat_i  (lut_rd_q),
    .vld_o  (tree_vld),
    .idx_o  (tree_idx),
    .sum_o  (tree_sum)
  );

  // Weight the tree sum by 2^j; the sign extension keeps the product exact.
  always_comb begin
    acc_shift = {{(ACC_W-SUM_W){tree_sum[SUM_W-1]}}, tree_sum} << tree_idx;
  end

  // Shift-accumulate; the MSB slice carries negative weight for two's-complement samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      acc_idx_q <= '0;
    end else begin
      acc_vld_q <= tree_vld;
      acc_idx_q <= tree_idx;
      if (state_q == ST_IDLE && start) begin
        acc_q <= '0;
      end else if (tree_vld) begin
        if (tree_idx == LAST_IDX) acc_q <= acc_q - acc_shift;
        else                      acc_q <= acc_q + acc_shift;
      end
    end
  end

  assign load_y = (state_q == ST_DRAIN) && (state_d == ST_DONE);

`ifdef DA_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic sat_q, sat_d;

  // Clamp the exact result into the signed OUT_W range and flag when it bites.
  always_comb begin
    y_d   = acc_q;
    sat_d = 1'b0;
    if (acc_q > SAT_MAX) begin
      y_d   = SAT_MAX;
      sat_d = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      y_d   = SAT_MIN;
      sat_d = 1'b1;
    end
  end

  // Clamp flag is captured together with the result.
  always_ff @(posedge clk) begin
    if (reset)       sat_q <= 1'b0;
    else if (load_y) sat_q <= sat_d;
  end

  assign sat = sat_q;
`else
  assign y_d = acc_q;
`endif

  // Result register: loaded on entry to DONE and held until the next completion.
  always_ff @(posedge clk) begin
    if (reset)       y_q <= '0;
    else if (load_y) y_q <= y_d;
  end

  assign y_out = y_q;

endmodule

// File: tb/tb_da_fir_engine.sv
// Randomised self-checking bench for da_fir_engine against a dot-product reference model.
// Covers reset state, single/negative/all taps, stalls, ignored start/cload, mid-run reset.
// With DA_SATURATE_EN defined it also covers the OUT_W clamp and sat flag.
module tb_da_fir_engine;
  localparam int NBANK  = 8;
  localparam int K      = 8;
  localparam int COEF_W = 20;
  localparam int DATA_W = 16;
  localparam int NTAP   = NBANK * K;
  localparam int ACC_W  = COEF_W + 3 + DATA_W;
`ifdef DA_SATURATE_EN
  localparam int OUT_W = 16;
`else
  localparam int OUT_W = 24;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               cload;
  logic [10:0]        caddr;
  logic [COEF_W-1:0]  cin;
  logic               start;
  logic [NTAP-1:0]    slice_in;
  logic               slice_valid;
  logic               slice_ready;
  logic               busy;
  logic               done;
  logic [ACC_W-1:0]   y_out;
`ifdef DA_SATURATE_EN
  logic               sat;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int h [NTAP];
  int x [NTAP];

  da_fir_engine #(
    .NBANK(NBANK), .K(K), .COEF_W(COEF_W), .DATA_W(DATA_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .cload(cload), .caddr(caddr), .cin(cin),
    .start(start), .slice_in(slice_in), .slice_valid(slice_valid),
    .slice_ready(slice_ready), .busy(busy), .done(done), .y_out(y_out)
`ifdef DA_SATURATE_EN
    , .sat(sat)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain dot product of taps and samples, then optional clamp.
  function automatic longint model_full();
    longint s;
    s = 0;
    for (int t = 0; t < NTAP; t++) s += longint'(h[t]) * longint'(x[t]);
    return s;
  endfunction

  function automatic logic signed [63:0] model_y();
    longint s, lim;
    s = model_full();
`ifdef DA_SATURATE_EN
    lim = longint'(1) << (OUT_W - 1);
    if (s > lim - 1) s = lim - 1;
    if (s < -lim)    s = -lim;
`endif
    return s;
  endfunction

  function automatic bit model_sat();
    longint s, lim;
    s = model_full();
    lim = longint'(1) << (OUT_W - 1);
    return (s > lim - 1) || (s < -lim);
  endfunction

  // Fill every bank: from taps (entry = sum of selected taps) or the clamp pattern.
  task automatic load_lut(input bit sat_pattern);
    int v;
    for (int b = 0; b < NBANK; b++) begin
      for (int a = 0; a < (1 << K); a++) begin
        v = 0;
        if (sat_pattern) v = (a == 255) ? 524287 : 0;
        else for (int k = 0; k < K; k++) if (a[k]) v += h[b*K + k];
        cload = 1'b1;
        caddr = 11'(b * 256 + a);
        cin   = 20'(v);
        @(posedge clk); #1;
      end
    end
    cload = 1'b0;
  endtask

  task automatic drive_slice(input int j);
    for (int t = 0; t < NTAP; t++) slice_in[t] = x[t][j];
    slice_valid = 1'b1;
  endtask

  task automatic run_output(input string tag, input int stall_mode, input bit busy_start,
                            input logic signed [63:0] exp_y, input bit exp_sat);
    int lat;
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int j = 0; j < DATA_W; j++) begin
      if (j > 0 && (stall_mode == 1 || (stall_mode == 2 && $urandom_range(0, 2) == 0))) begin
        slice_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
      end
      drive_slice(j);
      if (busy_start && j == 4) start = 1'b1;
      if (j < DATA_W - 1) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      slice_valid = 1'b0;
      start = 1'b0;
      lat++;
    end while (done !== 1'b1 && lat < 20);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_y"}, $signed(y_out), exp_y);
`ifdef DA_SATURATE_EN
    check({tag, "_sat"}, sat, exp_sat);
`else
    if (exp_sat) $display("note: %s result exceeds OUT_W, full value expected", tag);
`endif
    if (busy_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    repeat (3) @(posedge clk);
    #1;
    if (busy_start) check({tag, "_idle_after"}, busy, 0);
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic set_single(input int x0);
    for (int t = 0; t < NTAP; t++) begin h[t] = 0; x[t] = 0; end
    h[0] = 1;
    x[0] = x0;
  endtask

  initial begin
    int d0;
    reset = 1'b1; cload = 1'b0; caddr = '0; cin = '0;
    start = 1'b0; slice_in = '0; slice_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", slice_ready, 0);
    check("rst_y", $signed(y_out), 0);
`ifdef DA_SATURATE_EN
    check("rst_sat", sat, 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    set_single(5);
    load_lut(1'b0);
    run_output("single", 0, 1'b0, model_y(), model_sat());

    set_single(-3);
    run_output("negative", 0, 1'b0, model_y(), model_sat());

    for (int t = 0; t < NTAP; t++) begin h[t] = 1; x[t] = 1; end
    load_lut(1'b0);
    run_output("alltaps", 0, 1'b0, model_y(), model_sat());
    run_output("stall", 1, 1'b1, model_y(), model_sat());

    // Abort mid-run; a write attempted while busy must not reach the table.
    set_single(5);
    load_lut(1'b0);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 7; j++) begin
      drive_slice(j);
      if (j == 3) begin cload = 1'b1; caddr = 11'd1; cin = 20'd99; end
      @(posedge clk); #1;
      cload = 1'b0;
    end
    slice_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_y", $signed(y_out), 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", slice_ready, 0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    run_output("after_rst", 0, 1'b0, model_y(), model_sat());

    for (int it = 0; it < 4; it++) begin
      for (int t = 0; t < NTAP; t++) begin
        h[t] = int'($urandom_range(0, 4095)) - 2048;
        x[t] = int'($signed(16'($urandom)));
      end
      load_lut(1'b0);
      run_output($sformatf("rand%0d", it), 2, 1'b0, model_y(), model_sat());
    end

`ifdef DA_SATURATE_EN
    load_lut(1'b1);
    for (int t = 0; t < NTAP; t++) x[t] = 32767;
    run_output("sat_pos", 0, 1'b0, 64'sd32767, 1'b1);
    for (int t = 0; t < NTAP; t++) x[t] = -32767;
    run_output("sat_neg", 0, 1'b0, -64'sd32768, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/da_fir_engine.md
Name: da_fir_engine

Overview:
- Parametrised distributed-arithmetic MAC engine; next generation of the fixed 8-bank DA core.
- Per output: accepts DATA_W bit-slices of the tap samples, LSB first. Each slice addresses NBANK internal coefficient LUTs. LUT outputs are summed in a pipelined adder tree and shift-accumulated. The MSB slice is subtracted, giving two's-complement samples.
- Sits between the sample shift-register/slicer and the FIR output register.

Parameters:
- NBANK, 8, number of LUT banks; power of 2, 2..16.
- K, 8, LUT address width = taps per bank; each bank holds 2^K entries.
- COEF_W, 20, signed LUT entry width.
- DATA_W, 16, sample width = slices per output.
- OUT_W, 24, saturation width; used only with DA_SATURATE_EN.
- Derived: LB = log2(NBANK); ACC_W = COEF_W + LB + DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset: synchronous, active-high.
- cload  in  1  coefficient write strobe.
- caddr  in  LB+K  write address = {bank, entry}.
- cin  in  COEF_W  write data.
- start  in  1  begin one output computation.
- slice_in  in  NBANK*K  current bit-slice; bank b address = slice_in[b*K +: K].
- slice_valid  in  1  slice_in valid this cycle.
- slice_ready  out  1  engine accepts a slice when slice_valid is also high.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse; y_out valid.
- y_out  out  ACC_W  signed result; held until the next done.

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy, done, slice_ready, y_out = 0; pipeline valid tags, slice counter and accumulator cleared. LUT contents are not reset.
- States:
  - IDLE: start → RUN; slice counter j = 0, accumulator = 0.
  - RUN: slice_ready = 1. Each accepted slice increments j. The accepted slice with j = DATA_W-1 → DRAIN.
  - DRAIN: waits until the last slice's valid tag leaves the accumulate stage → DONE.
  - DONE: done = 1 for one cycle; y_out loaded → IDLE.
- Pipeline, each stage registered and carrying a valid tag and slice index:
  - LUT read: 1 cycle.
  - Adder tree: LB levels; level n is COEF_W+n bits, sign-extended.
  - Accumulate: 1 cycle. acc += sext(sum) << j for j < DATA_W-1; acc -= sext(sum) << j for j = DATA_W-1.
- Latency: last slice accepted at cycle T → done at T+LB+3. For LB=3 that is T+6.
- Stalls: slice_valid low in RUN inserts a bubble; bubbles never update acc. Back-to-back slices are accepted at full rate.
- Arithmetic is exact in ACC_W; no overflow is possible.
- start while busy: ignored. start in the same cycle as done: ignored; re-issue from IDLE.
- cload: writes only in IDLE. Ignored in other states; no error flag.
- cload and start in the same IDLE cycle: the write completes; the first LUT read sees it.
- slice_valid outside RUN: ignored.
- reset mid-RUN/DRAIN: abort immediately; no done; y_out = 0.

Optional Feature:
- Macro DA_SATURATE_EN.
- Defined: y_out = acc clamped to the signed OUT_W range, then sign-extended to ACC_W. Adds output register flag sat (out, 1) = clamp occurred; updated with done, reset 0.
- Undefined: y_out = full acc; no sat port.

Decomposition:
- Package da_pkg:
  - Functions: clog2, ACC_W derivation.
  - State encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - Slice-index width constant.
- Sub-module da_adder_tree: parametrised by NBANK and COEF_W; registered levels with valid/index sideband.
- LUT array and FSM stay in da_fir_engine.

Test Plan (NBANK=8, K=8, COEF_W=20, DATA_W=16 unless noted):
- Single tap: bank0 entry 1 = 1, all other entries 0; x0 = 5, slices bank0 addr = 1,0,1,0…; start → y_out = 5, done 6 cycles after the last slice.
- Negative sample: same LUT, x0 = -3 (0xFFFD) → y_out = -3. Checks MSB subtraction.
- All 64 taps with h = 1: every bank entry a = popcount(a); all samples = 1 (slice0 addr = 0xFF per bank, other slices 0) → y_out = 64.
- Stalls and busy start: same as the all-taps case, slice_valid deasserted every other cycle; start pulsed while busy → y_out = 64, exactly one done.
- Reset mid-RUN after 7 slices, then a fresh single-tap run → no done before reset; y_out = 0 after reset; second run gives 5. Also check a cload issued while busy leaves the LUT unchanged.
- DA_SATURATE_EN, OUT_W = 16: all 0xFF entries = 524287, all others 0; all samples = 32767 → y_out = 32767, sat = 1. Negate the samples → y_out = -32768.
